cnn_pixel_stream_feeder: RTL and testbench
==========================================

# cnn_pixel_stream_feeder

Upstream pixel source for the CNN processing core. It accepts packed 32-bit pixel words on an AXI4-Stream slave, typically from a DMA engine, and unpacks them into the byte-wide `pixel_valid`/`pixel_data` stream the core consumes. It issues the per-frame `cnn_start`/`frame_start` pulses and enforces an exact frame length, padding short frames and discarding the excess of long ones. This replaces per-pixel MicroBlaze register writes for full-rate frames; status and error outputs map onto the existing CNN register block.

## Interface
- `IMG_W`, default 32: frame width in pixels.
- `IMG_H`, default 32: frame height in pixels. `FRAME_PIXELS = IMG_W*IMG_H` must be a multiple of 4. `WORDS = FRAME_PIXELS/4`.
- `clk` input, 1 bit: single clock for all logic.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `enable` input, 1 bit: permits starting a new frame. It is level-sensitive and sampled only in IDLE.
- `soft_clear` input, 1 bit: synchronous pulse that returns the block to its reset state.
- `error_clear` input, 1 bit: synchronous pulse that clears `err_flags`.
- `s_axis_tdata` input, 32 bits: four pixels. Byte 0 (`[7:0]`) is the first pixel.
- `s_axis_tvalid` input, 1 bit: stream valid.
- `s_axis_tready` output, 1 bit: stream ready.
- `s_axis_tlast` input, 1 bit: marks the last word of a frame.
- `cnn_busy` input, 1 bit: the core is processing.
- `cnn_start` output, 1 bit: one-cycle start pulse to the core.
- `frame_start` output, 1 bit: one-cycle pulse, coincident with `cnn_start`.
- `pixel_valid` output, 1 bit: pixel strobe.
- `pixel_data` output, 8 bits: pixel value.
- `frame_complete` output, 1 bit: one-cycle pulse after the last pixel of a frame.
- `frame_count` output, 32 bits: completed frames. Wraps from 2^32-1 to 0.
- `err_flags` output, 2 bits, sticky: `[0]` short frame, `[1]` long frame.

## Operation
- States: IDLE, START, LOAD, EMIT, PAD, DONE, FLUSH.
- **IDLE:** `s_axis_tready`=0. Moves to START when `enable && !cnn_busy && s_axis_tvalid`. Otherwise it waits without flagging an error.
- **START:** asserts `cnn_start` and `frame_start` for one cycle. Clears the pixel counter (`$clog2(FRAME_PIXELS+1)` bits) and the word counter. Moves to LOAD.
- **LOAD:** `s_axis_tready`=1. On handshake it latches tdata and tlast, sets byte index to 0, increments the word counter, and moves to EMIT.
- **EMIT:** `pixel_valid`=1. `pixel_data` = the latched byte at the current index, so pixels go out LSB byte first. The pixel counter increments every cycle.
- **At byte index 3 in EMIT:**
  - If the current word is the frame's last word (word counter = WORDS), go to DONE. If its tlast was 0, set `err_flags[1]` and flag FLUSH-after-DONE.
  - Else if the latched tlast is 1 (short frame), set `err_flags[0]` and go to PAD.
  - Otherwise `s_axis_tready`=1 in this same cycle. A handshake reloads the word and stays in EMIT, giving gapless output. Without a handshake, go to LOAD.
- **PAD:** `pixel_valid`=1 and `pixel_data`=0 until the pixel counter reaches FRAME_PIXELS, then go to DONE. `s_axis_tready`=0.
- **DONE:** `frame_complete`=1 for one cycle and `frame_count` increments. Goes to FLUSH if flagged, else IDLE.
- **FLUSH:** `s_axis_tready`=1. Discards words until a handshake with tlast=1, then goes to IDLE. No pixels are emitted.
- Dropping `enable` mid-frame has no effect; the current frame always completes.
- `soft_clear` has priority over all state activity. It forces IDLE and zeroes the counters, `frame_count`, `err_flags`, and the data registers.
- If `error_clear` coincides with a new error being set, the set wins.

## Timing
- **Reset values (async, and via `soft_clear`):** every output is 0 and the state is IDLE.
- All outputs are registered or decoded from registered state. There is no combinational path from `s_axis_tvalid` to `pixel_valid`.
- **Start latency:** `cnn_start` is asserted the cycle after the IDLE start condition is sampled.
- The LOAD handshake follows in the next cycle when tvalid is held. The first `pixel_valid` comes in the cycle after that.
- With tvalid held continuously, a frame occupies 1 START + 1 LOAD + FRAME_PIXELS EMIT + 1 DONE cycles.
- `frame_complete` is high exactly one cycle after the last `pixel_valid`.
- Minimum IDLE dwell between frames is 1 cycle.
- Exactly FRAME_PIXELS `pixel_valid` cycles occur between `frame_start` and `frame_complete`, regardless of stream errors.
- `s_axis_tready` is never high in IDLE, START, PAD, or DONE.

## Test plan
- **Nominal frame:** 256 words, word n = {4n+3, 4n+2, 4n+1, 4n} mod 256 per byte, tlast on word 255, tvalid held. Required: one `cnn_start`, then 1024 consecutive `pixel_valid` cycles with `pixel_data` = i mod 256. `frame_complete` one cycle after the last pixel, `frame_count`=1, `err_flags`=0.
- **Backpressure:** the same frame with tvalid randomly deasserted about 50% of the time. Required: an identical pixel sequence, with gaps only at word boundaries and a final `frame_count`=1.
- **Short frame:** tlast on word 9. Required: pixels 0..39 carry data, followed by 984 zero pixels, `err_flags`=2'b01, and `frame_complete`. `error_clear` then returns `err_flags` to 0.
- **Long frame:** 260 words with tlast on word 259. Required: 1024 pixels from words 0..255, `err_flags`=2'b10, and words 256..259 accepted without `pixel_valid`. A following nominal frame is clean.
- **Busy/enable gating:** `cnn_busy`=1 (or `enable`=0) while tvalid=1. Required: no `cnn_start` and `s_axis_tready`=0. `cnn_start` fires the cycle after the gating condition clears.
- **Reset mid-frame:** assert `rst_n`=0 during word 100. Required: all outputs 0 immediately, without waiting for a clock edge. After release, a new frame runs nominally and `frame_count`=1 at its end.

Source files
------------

// File: rtl/cnn_pixel_stream_feeder_if.sv
// ============================================================================
//  Module   : cnn_pixel_stream_feeder_if
//  Purpose  : AXI4-Stream word channel feeding the CNN pixel stream feeder.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface cnn_pixel_stream_feeder_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/cnn_pixel_stream_feeder.sv
// ============================================================================
//  Module   : cnn_pixel_stream_feeder
//  Purpose  : Unpacks 32-bit AXI-Stream words into a fixed-length byte pixel
//             stream for the CNN core, padding short and trimming long frames.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cnn_pixel_stream_feeder #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          soft_clear,
  input  logic                          error_clear,
  cnn_pixel_stream_feeder_if.slave      s_axis,
  input  logic                          cnn_busy,
  output logic                          cnn_start,
  output logic                          frame_start,
  output logic                          pixel_valid,
  output logic [7:0]                    pixel_data,
  output logic                          frame_complete,
  output logic [31:0]                   frame_count,
  output logic [1:0]                    err_flags
);

  localparam int FRAME_PIXELS = IMG_W * IMG_H;
  localparam int WORDS        = FRAME_PIXELS / 4;
  localparam int PIX_W        = $clog2(FRAME_PIXELS + 1);
  localparam int WORD_W       = $clog2(WORDS + 1);

  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_PAD   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_FLUSH = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]       data_q, data_d;
  logic              last_q, last_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              flush_q, flush_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       frame_count_q, frame_count_d;

  logic [1:0]        err_set;
  logic              tready;

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    word_cnt_d    = word_cnt_q;
    data_d        = data_q;
    last_d        = last_q;
    byte_idx_d    = byte_idx_q;
    flush_d       = flush_q;
    frame_count_d = frame_count_q;
    err_set       = 2'b00;
    tready        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && !cnn_busy && s_axis.tvalid) state_d = S_START;
      end
      S_START: begin
        pix_cnt_d  = '0;
        word_cnt_d = '0;
        flush_d    = 1'b0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        tready = 1'b1;
        if (s_axis.tvalid) begin
          data_d     = s_axis.tdata;
          last_d     = s_axis.tlast;
          byte_idx_d = 2'd0;
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        pix_cnt_d = pix_cnt_q + 1'b1;
        if (byte_idx_q != 2'd3) begin
          byte_idx_d = byte_idx_q + 2'd1;
        end else if (word_cnt_q == LAST_WORD) begin
          state_d = S_DONE;
          if (!last_q) begin
            err_set[1] = 1'b1;
            flush_d    = 1'b1;
          end
        end else if (last_q) begin
          err_set[0] = 1'b1;
          state_d    = S_PAD;
        end else begin
          // Accepting the next word on the last byte keeps the output gapless.
          tready = 1'b1;
          if (s_axis.tvalid) begin
            data_d     = s_axis.tdata;
            last_d     = s_axis.tlast;
            byte_idx_d = 2'd0;
            word_cnt_d = word_cnt_q + 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_PAD: begin
        pix_cnt_d = pix_cnt_q + 1'b1;
        if (pix_cnt_q == LAST_PIX) state_d = S_DONE;
      end
      S_DONE: begin
        frame_count_d = frame_count_q + 32'd1;
        flush_d       = 1'b0;
        state_d       = flush_q ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        tready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A newly detected error beats a simultaneous clear.
    err_d = (error_clear ? 2'b00 : err_q) | err_set;

    if (soft_clear) begin
      state_d       = S_IDLE;
      pix_cnt_d     = '0;
      word_cnt_d    = '0;
      data_d        = '0;
      last_d        = 1'b0;
      byte_idx_d    = 2'd0;
      flush_d       = 1'b0;
      err_d         = 2'b00;
      frame_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pix_cnt_q     <= '0;
      word_cnt_q    <= '0;
      data_q        <= '0;
      last_q        <= 1'b0;
      byte_idx_q    <= 2'd0;
      flush_q       <= 1'b0;
      err_q         <= 2'b00;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      word_cnt_q    <= word_cnt_d;
      data_q        <= data_d;
      last_q        <= last_d;
      byte_idx_q    <= byte_idx_d;
      flush_q       <= flush_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    pixel_data = 8'd0;
    if (state_q == S_EMIT) begin
      case (byte_idx_q)
        2'd0:    pixel_data = data_q[7:0];
        2'd1:    pixel_data = data_q[15:8];
        2'd2:    pixel_data = data_q[23:16];
        default: pixel_data = data_q[31:24];
      endcase
    end
  end

  assign s_axis.tready  = tready;
  assign cnn_start      = (state_q == S_START);
  assign frame_start    = (state_q == S_START);
  assign pixel_valid    = (state_q == S_EMIT) || (state_q == S_PAD);
  assign frame_complete = (state_q == S_DONE);
  assign frame_count    = frame_count_q;
  assign err_flags      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_pixel_stream_feeder.sv
// ============================================================================
//  Module   : tb_cnn_pixel_stream_feeder
//  Purpose  : Directed self-checking bench for cnn_pixel_stream_feeder.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cnn_pixel_stream_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        soft_clear = 1'b0;
  logic        error_clear = 1'b0;
  logic        cnn_busy = 1'b0;
  logic        cnn_start, frame_start, pixel_valid, frame_complete;
  logic [7:0]  pixel_data;
  logic [31:0] frame_count;
  logic [1:0]  err_flags;

  cnn_pixel_stream_feeder_if s_if ();

  cnn_pixel_stream_feeder #(.IMG_W(32), .IMG_H(32)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .soft_clear     (soft_clear),
    .error_clear    (error_clear),
    .s_axis         (s_if),
    .cnn_busy       (cnn_busy),
    .cnn_start      (cnn_start),
    .frame_start    (frame_start),
    .pixel_valid    (pixel_valid),
    .pixel_data     (pixel_data),
    .frame_complete (frame_complete),
    .frame_count    (frame_count),
    .err_flags      (err_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int n);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((4*n + k) & 255);
    return w;
  endfunction

  // Stream monitor; the stimulus process restarts it by bumping mon_gen.
  int mon_gen = 0, seen_gen = 0, data_pix = 1024;
  int start_cnt, pix_idx, pix_bad, fc_cnt, fc_bad, fs_bad, gap_bad;
  int extra, tr_bad, hole_cnt, first_lat, lat_cnt, pix_at_fc;
  bit lat_on, in_frame, prev_pv;
  logic [7:0] exp_pix;

  always @(negedge clk) begin
    if (mon_gen != seen_gen) begin
      seen_gen = mon_gen;
      start_cnt = 0; pix_idx = 0; pix_bad = 0; fc_cnt = 0; fc_bad = 0;
      fs_bad = 0; gap_bad = 0; extra = 0; tr_bad = 0; hole_cnt = 0;
      first_lat = -1; lat_cnt = 0; pix_at_fc = 0;
      lat_on = 1'b0; in_frame = 1'b0; prev_pv = 1'b0;
    end
    if (frame_start !== cnn_start) fs_bad++;
    if (cnn_start) begin
      start_cnt++; in_frame = 1'b1; pix_idx = 0; lat_cnt = 0; lat_on = 1'b1;
      if (s_if.tready) tr_bad++;
    end else if (lat_on) begin
      lat_cnt++;
      if (pixel_valid) begin first_lat = lat_cnt; lat_on = 1'b0; end
    end
    if (frame_complete) begin
      fc_cnt++;
      if (!prev_pv) fc_bad++;
      pix_at_fc = pix_idx; in_frame = 1'b0;
      if (s_if.tready) tr_bad++;
    end
    if (pixel_valid) begin
      if (!in_frame) extra++;
      else begin
        exp_pix = (pix_idx < data_pix) ? 8'(pix_idx & 255) : 8'd0;
        if (pixel_data !== exp_pix) pix_bad++;
        if (pix_idx >= data_pix && s_if.tready) tr_bad++;
        if (!prev_pv && pix_idx > 0 && (pix_idx % 4) != 0) gap_bad++;
        pix_idx++;
      end
    end else if (in_frame && pix_idx > 0 && !frame_complete) begin
      hole_cnt++;
    end
    prev_pv = pixel_valid;
  end

  // Sends words 0..stop_w-1; with bp set, tvalid toggles randomly but is held until accepted.
  task automatic drive_frame(input int last_w, input bit bp, input int stop_w, input int budget);
    int w = 0;
    int cyc = 0;
    bit hs = 1'b1;
    while (w < stop_w && cyc < budget) begin
      if (!bp) s_if.tvalid = 1'b1;
      else if (hs || !s_if.tvalid) s_if.tvalid = ($urandom_range(0, 1) == 1);
      s_if.tdata = word_of(w);
      s_if.tlast = (w == last_w);
      @(negedge clk);
      hs = s_if.tvalid && s_if.tready;
      @(posedge clk);
      #1;
      if (hs) w++;
      cyc++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    check("drive_words", w, stop_w);
  endtask

  task automatic wait_fc(input int budget);
    int c = 0;
    while (fc_cnt == 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("fc_seen", 32'(fc_cnt != 0), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int nwords, input int last_w, input bit bp, input int dp);
    mon_gen++;
    data_pix = dp;
    drive_frame(last_w, bp, nwords, 6000);
    wait_fc(3000);
  endtask

  task automatic frame_checks(input int exp_fc, input logic [1:0] exp_err, input bit strict);
    check("starts", start_cnt, 1);
    check("pixels", pix_at_fc, 1024);
    check("pix_data", pix_bad, 0);
    check("fc_pulses", fc_cnt, 1);
    check("fc_after_last_pv", fc_bad, 0);
    check("frame_start_align", fs_bad, 0);
    check("gap_mid_word", gap_bad, 0);
    check("pv_outside_frame", extra, 0);
    check("tready_illegal", tr_bad, 0);
    check("frame_count", frame_count, exp_fc);
    check("err_flags", {30'd0, err_flags}, {30'd0, exp_err});
    if (strict) begin
      check("holes", hole_cnt, 0);
      check("first_pv_latency", first_lat, 2);
    end
  endtask

  function automatic logic [31:0] outs();
    return {17'd0, cnn_start, frame_start, pixel_valid, pixel_data,
            frame_complete, s_if.tready, err_flags};
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_outs", outs(), 0);
    check("rst_frame_count", frame_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;

    run_frame(256, 255, 1'b0, 1024);
    frame_checks(1, 2'b00, 1'b1);

    run_frame(256, 255, 1'b1, 1024);
    frame_checks(2, 2'b00, 1'b0);

    run_frame(10, 9, 1'b0, 40);
    frame_checks(3, 2'b01, 1'b0);
    error_clear = 1'b1;
    @(posedge clk); #1;
    error_clear = 1'b0;
    check("err_cleared", {30'd0, err_flags}, 0);

    run_frame(260, 259, 1'b0, 1024);
    frame_checks(4, 2'b10, 1'b1);
    check("flush_done_tready", {31'd0, s_if.tready}, 0);

    run_frame(256, 255, 1'b0, 1024);
    frame_checks(5, 2'b10, 1'b1);

    soft_clear = 1'b1;
    @(posedge clk); #1;
    soft_clear = 1'b0;
    check("soft_clear_fcount", frame_count, 0);
    check("soft_clear_err", {30'd0, err_flags}, 0);

    // Gating: tvalid pending while enable low, then while core busy.
    mon_gen++;
    data_pix = 1024;
    s_if.tdata = word_of(0); s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    enable = 1'b0; cnn_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("gate_en_start", {31'd0, cnn_start}, 0);
      check("gate_en_tready", {31'd0, s_if.tready}, 0);
    end
    @(posedge clk); #1;
    enable = 1'b1; cnn_busy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("gate_busy_start", {31'd0, cnn_start}, 0);
      check("gate_busy_tready", {31'd0, s_if.tready}, 0);
    end
    @(posedge clk); #1;
    cnn_busy = 1'b0;
    @(negedge clk);
    check("start_not_early", {31'd0, cnn_start}, 0);
    @(negedge clk);
    check("start_after_clear", {31'd0, cnn_start}, 1);
    @(posedge clk); #1;
    drive_frame(255, 1'b0, 256, 6000);
    wait_fc(3000);
    frame_checks(1, 2'b00, 1'b1);

    // Asynchronous reset in the middle of word 100.
    mon_gen++;
    drive_frame(255, 1'b0, 100, 6000);
    #2;
    check("pv_before_rst", {31'd0, pixel_valid}, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", outs(), 0);
    check("rst_async_fcount", frame_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(256, 255, 1'b0, 1024);
    frame_checks(1, 2'b00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
